// File: rtl/ppm_symbol_packer_if.sv
// ppm_symbol_packer_if
//   Bundles the symbol-side inputs and the word-side valid/ready outputs of
//   ppm_symbol_packer so that the decoder, packer and consumer share one
//   connection.
//   slave  : packer view (symbols and dout_ready in; word, pulses and count out)
//   master : driver/consumer view (the opposite directions)
//   Signals: sym_in (erasure flag + symbol), sym_valid, frame_start,
//            dout, dout_valid, dout_ready, sym_err, overflow, timeout, sym_count
interface ppm_symbol_packer_if #(
    parameter int unsigned SYM_BITS = 2,
    parameter int unsigned OUT_W    = 8
);
    logic [SYM_BITS:0]                    sym_in;
    logic                                 sym_valid;
    logic                                 frame_start;
    logic [OUT_W-1:0]                     dout;
    logic                                 dout_valid;
    logic                                 dout_ready;
    logic                                 sym_err;
    logic                                 overflow;
    logic                                 timeout;
    logic [$clog2(OUT_W/SYM_BITS):0]      sym_count;

    modport slave (
        input  sym_in, sym_valid, frame_start, dout_ready,
        output dout, dout_valid, sym_err, overflow, timeout, sym_count
    );

    modport master (
        output sym_in, sym_valid, frame_start, dout_ready,
        input  dout, dout_valid, sym_err, overflow, timeout, sym_count
    );
endinterface

// File: rtl/ppm_symbol_packer.sv
// ppm_symbol_packer
//   Collects decoded PPM symbols (SYM_BITS each) into OUT_W-bit words in
//   MSB-first or LSB-first order, with erasure handling, frame resync, an
//   inter-symbol timeout and a valid/ready output holding register.
//   Ports:
//     clk16  - sole clock
//     rst_n  - synchronous active-low reset
//     bus    - ppm_symbol_packer_if.slave: sym_in/sym_valid/frame_start in,
//              dout/dout_valid (with dout_ready in), sym_err/overflow/timeout
//              one-cycle pulses, sym_count (symbols in the partial word)
module ppm_symbol_packer #(
    parameter int unsigned SYM_BITS  = 2,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                  clk16,
    input  logic                  rst_n,
    ppm_symbol_packer_if.slave    bus
);
    localparam int unsigned N  = OUT_W / SYM_BITS;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [OUT_W-1:0]  shift_q, shift_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [OUT_W-1:0]  dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              to_q, to_d;

    logic [OUT_W-1:0]  sym_ext;
    logic [OUT_W-1:0]  assembled;
    logic              out_free;

    always_ff @(posedge clk16) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
            idle_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            idle_q  <= idle_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        idle_d  = idle_q;
        dout_d  = dout_q;
        // A consumed word drops valid unless a new word loads below.
        valid_d = valid_q && !bus.dout_ready;
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        to_d    = 1'b0;

        sym_ext = OUT_W'(bus.sym_in[SYM_BITS-1:0]);
        // Shift-based form keeps the single-symbol-per-word case legal.
        if (MSB_FIRST != 0) begin
            assembled = (shift_q << SYM_BITS) | sym_ext;
        end else begin
            assembled = (shift_q >> SYM_BITS) | (sym_ext << (OUT_W - SYM_BITS));
        end
        out_free = !valid_q || bus.dout_ready;

        if (bus.frame_start) begin
            state_d = IDLE;
            count_d = '0;
            shift_d = '0;
            idle_d  = '0;
        end else if (bus.sym_valid) begin
            idle_d = '0;
            if (bus.sym_in[SYM_BITS]) begin
                err_d   = 1'b1;
                state_d = IDLE;
                count_d = '0;
                shift_d = '0;
            end else if (count_q == CW'(N - 1)) begin
                state_d = IDLE;
                count_d = '0;
                shift_d = '0;
                if (out_free) begin
                    dout_d  = assembled;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                state_d = ACCUM;
                count_d = count_q + 1'b1;
                shift_d = assembled;
            end
        end else if (state_q == ACCUM && TIMEOUT > 0) begin
            // Firing on TIMEOUT-1 puts the pulse TIMEOUT cycles after the strobe.
            if (idle_q == TW'(TIMEOUT - 1)) begin
                to_d    = 1'b1;
                state_d = IDLE;
                count_d = '0;
                shift_d = '0;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.sym_err    = err_q;
    assign bus.overflow   = ovf_q;
    assign bus.timeout    = to_q;
    assign bus.sym_count  = count_q;

endmodule

// File: tb/tb_ppm_symbol_packer.sv
module tb_ppm_symbol_packer;
    logic clk16;
    logic rst_n;

    // Shared stimulus for the two 2/8 instances (MSB-first and LSB-first).
    logic [2:0] sym_in;
    logic       sym_valid;
    logic       frame_start;
    logic       dout_ready;

    // Stimulus for the 4/16 instance.
    logic [4:0] s16_in;
    logic       s16_valid;

    int tests;
    int fails;

    ppm_symbol_packer_if #(.SYM_BITS(2), .OUT_W(8))  bus_m ();
    ppm_symbol_packer_if #(.SYM_BITS(2), .OUT_W(8))  bus_l ();
    ppm_symbol_packer_if #(.SYM_BITS(4), .OUT_W(16)) bus_w ();

    assign bus_m.sym_in      = sym_in;
    assign bus_m.sym_valid   = sym_valid;
    assign bus_m.frame_start = frame_start;
    assign bus_m.dout_ready  = dout_ready;
    assign bus_l.sym_in      = sym_in;
    assign bus_l.sym_valid   = sym_valid;
    assign bus_l.frame_start = frame_start;
    assign bus_l.dout_ready  = dout_ready;
    assign bus_w.sym_in      = s16_in;
    assign bus_w.sym_valid   = s16_valid;
    assign bus_w.frame_start = 1'b0;
    assign bus_w.dout_ready  = 1'b1;

    ppm_symbol_packer #(.SYM_BITS(2), .OUT_W(8), .MSB_FIRST(1), .TIMEOUT(64))
        dut_m (.clk16(clk16), .rst_n(rst_n), .bus(bus_m));
    ppm_symbol_packer #(.SYM_BITS(2), .OUT_W(8), .MSB_FIRST(0), .TIMEOUT(64))
        dut_l (.clk16(clk16), .rst_n(rst_n), .bus(bus_l));
    ppm_symbol_packer #(.SYM_BITS(4), .OUT_W(16), .MSB_FIRST(1), .TIMEOUT(64))
        dut_w (.clk16(clk16), .rst_n(rst_n), .bus(bus_w));

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] syms;     // first symbol in [7:6]
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk16);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] s, input logic era);
        sym_in    = {era, s};
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        sym_in    = 3'b100;   // idle code: erasure flag without strobe
    endtask

    initial begin
        logic [7:0]  v;
        logic [15:0] w;
        int          seen;

        tests = 0;
        fails = 0;
        vecs[0] = '{syms: 8'b01_00_10_11, exp_msb: 8'h4B, exp_lsb: 8'hE1};
        vecs[1] = '{syms: 8'b11_11_11_11, exp_msb: 8'hFF, exp_lsb: 8'hFF};
        vecs[2] = '{syms: 8'b10_11_00_01, exp_msb: 8'hB1, exp_lsb: 8'h4E};
        vecs[3] = '{syms: 8'b11_10_01_00, exp_msb: 8'hE4, exp_lsb: 8'h1B};

        rst_n       = 1'b0;
        sym_in      = 3'b000;
        sym_valid   = 1'b0;
        frame_start = 1'b0;
        dout_ready  = 1'b1;
        s16_in      = 5'd0;
        s16_valid   = 1'b0;
        tick();
        tick();
        check("rst_dout",     32'(bus_m.dout), 32'h0);
        check("rst_valid",    32'(bus_m.dout_valid), 32'h0);
        check("rst_count",    32'(bus_m.sym_count), 32'h0);
        check("rst_pulses",   32'({bus_m.sym_err, bus_m.overflow, bus_m.timeout}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Word assembly, symbols spaced 9 cycles, both packing orders.
        for (int i = 0; i < 4; i++) begin
            v = vecs[i].syms;
            for (int j = 0; j < 4; j++) begin
                send(v[7-2*j -: 2], 1'b0);
                if (j < 3) begin
                    check("count_m", 32'(bus_m.sym_count), 32'(j + 1));
                    check("valid_early", 32'(bus_m.dout_valid), 32'h0);
                    repeat (8) tick();
                end else begin
                    check("count_wrap", 32'(bus_m.sym_count), 32'h0);
                    check("valid_m", 32'(bus_m.dout_valid), 32'h1);
                    check("dout_m", 32'(bus_m.dout), 32'(vecs[i].exp_msb));
                    check("valid_l", 32'(bus_l.dout_valid), 32'h1);
                    check("dout_l", 32'(bus_l.dout), 32'(vecs[i].exp_lsb));
                end
            end
            tick();
            check("valid_drop", 32'({bus_m.dout_valid, bus_l.dout_valid}), 32'h0);
            repeat (7) tick();
        end

        // 4-bit symbols into 16-bit words.
        w = 16'hABCD;
        for (int j = 0; j < 4; j++) begin
            s16_in    = {1'b0, w[15-4*j -: 4]};
            s16_valid = 1'b1;
            tick();
            s16_valid = 1'b0;
        end
        check("w16_valid", 32'(bus_w.dout_valid), 32'h1);
        check("w16_dout",  32'(bus_w.dout), 32'h0000ABCD);
        tick();

        // Overflow while the output register is full, then a gapless reload.
        dout_ready = 1'b0;
        send(2'd1, 1'b0); send(2'd0, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0);
        check("ovf_first", 32'(bus_m.dout), 32'h4B);
        send(2'd3, 1'b0); send(2'd2, 1'b0); send(2'd1, 1'b0); send(2'd0, 1'b0);
        check("ovf_pulse", 32'(bus_m.overflow), 32'h1);
        check("ovf_hold",  32'(bus_m.dout), 32'h4B);
        check("ovf_valid", 32'(bus_m.dout_valid), 32'h1);
        tick();
        check("ovf_once",  32'(bus_m.overflow), 32'h0);
        send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0);
        dout_ready = 1'b1;
        send(2'd3, 1'b0);
        check("reload_valid", 32'(bus_m.dout_valid), 32'h1);
        check("reload_dout",  32'(bus_m.dout), 32'h1B);
        check("reload_dout_l", 32'(bus_l.dout), 32'hE4);
        check("reload_no_ovf", 32'(bus_m.overflow), 32'h0);
        tick();
        check("reload_drop", 32'(bus_m.dout_valid), 32'h0);

        // Erasure drops the partial word.
        send(2'd1, 1'b0); send(2'd0, 1'b0);
        send(2'd0, 1'b1);
        check("era_pulse", 32'(bus_m.sym_err), 32'h1);
        check("era_count", 32'(bus_m.sym_count), 32'h0);
        tick();
        check("era_once", 32'(bus_m.sym_err), 32'h0);
        send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0); send(2'd1, 1'b0);
        check("era_dout", 32'(bus_m.dout), 32'hB1);
        check("era_valid", 32'(bus_m.dout_valid), 32'h1);
        tick();

        // frame_start coincident with a strobe: symbol ignored, dout untouched.
        send(2'd1, 1'b0); send(2'd0, 1'b0); send(2'd2, 1'b0);
        frame_start = 1'b1;
        send(2'd3, 1'b0);
        frame_start = 1'b0;
        check("fs_count", 32'(bus_m.sym_count), 32'h0);
        check("fs_valid", 32'(bus_m.dout_valid), 32'h0);
        check("fs_dout",  32'(bus_m.dout), 32'hB1);
        send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0); send(2'd1, 1'b0);
        check("fs_word", 32'(bus_m.dout), 32'hB1);
        check("fs_word_valid", 32'(bus_m.dout_valid), 32'h1);
        tick();

        // Inter-symbol timeout.
        send(2'd2, 1'b0); send(2'd1, 1'b0);
        seen = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus_m.dout_valid) seen = -1;
            if (bus_m.timeout && seen == 0) begin
                seen = k;
                break;
            end
        end
        check("to_delay", 32'(seen), 32'd64);
        check("to_count", 32'(bus_m.sym_count), 32'h0);
        tick();
        check("to_once", 32'(bus_m.timeout), 32'h0);

        // Reset mid-word and while a word is pending.
        send(2'd1, 1'b0); send(2'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_count", 32'(bus_m.sym_count), 32'h0);
        check("rst_mid_out", 32'({bus_m.dout, bus_m.dout_valid}), 32'h0);
        dout_ready = 1'b0;
        send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0); send(2'd1, 1'b0);
        check("rst_pre_dout", 32'(bus_m.dout), 32'hB1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_pend_out", 32'({bus_m.dout, bus_m.dout_valid}), 32'h0);
        dout_ready = 1'b1;
        send(2'd1, 1'b0); send(2'd0, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0);
        check("rst_after_dout", 32'(bus_m.dout), 32'h4B);
        check("rst_after_valid", 32'(bus_m.dout_valid), 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ppm_symbol_packer.md
Name: ppm_symbol_packer

Overview:
Parametrised successor to the 4-PPM byte assembler. It collects decoded PPM symbols of SYM_BITS each into OUT_W-bit words, in a selectable packing order. It adds erasure/error handling, frame resync, an inter-symbol timeout and a valid/ready output holding register. It sits between the PPM slot decoder (symbol strobe) and the byte/FIFO consumer, all in the clk16 domain.

Parameters:
SYM_BITS, 2, bits per PPM symbol (1..4; 2 = 4-PPM).
OUT_W, 8, output word width; must be a multiple of SYM_BITS.
MSB_FIRST, 1, 1 = first symbol lands in the top bits of dout; 0 = first symbol lands in the bottom bits.
TIMEOUT, 64, clk16 cycles without a symbol before a partial word is dropped; 0 disables the timeout.

Ports:
clk16  input  1  sole clock
rst_n  input  1  synchronous active-low reset
sym_in  input  SYM_BITS+1  [SYM_BITS] = erasure flag, [SYM_BITS-1:0] = symbol value
sym_valid  input  1  one-cycle strobe; sym_in is sampled on this cycle
frame_start  input  1  one-cycle resync; discards any partial word
dout  output  OUT_W  assembled word; stable while dout_valid is high
dout_valid  output  1  word available; held until accepted
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
sym_err  output  1  one-cycle pulse: erasure symbol received, partial word dropped
overflow  output  1  one-cycle pulse: completed word lost because the output register was full
timeout  output  1  one-cycle pulse: partial word dropped on inactivity
sym_count  output  $clog2(OUT_W/SYM_BITS)+1  symbols held in the partial word

Behaviour:
- N = OUT_W/SYM_BITS symbols per word.
- Reset (rst_n low at a clk16 edge):
  - dout=0, dout_valid=0, sym_err=0, overflow=0, timeout=0, sym_count=0.
  - Shift register and idle counter cleared.
  - Reset takes priority over every other input, including mid-word and while dout_valid is high; a pending word is lost.
- States:
  - IDLE: sym_count=0.
  - ACCUM: 0<sym_count<N.
  - Completion is handled in the cycle that sym_count would reach N; there is no separate state.
- Priority within one cycle: rst_n > frame_start > sym_valid > timeout.
- frame_start: sym_count←0, shift register←0, go to IDLE.
  - A sym_valid in the same cycle is ignored.
  - dout and dout_valid are unaffected.
- sym_valid with erasure flag set:
  - sym_err pulses the next cycle.
  - Partial word discarded, go to IDLE.
  - The symbol is not counted.
- sym_valid with erasure flag clear:
  - MSB_FIRST=1: shift ← {shift[OUT_W-SYM_BITS-1:0], sym}.
  - MSB_FIRST=0: shift ← {sym, shift[OUT_W-1:SYM_BITS]}.
  - sym_count increments.
- Erasure flag with sym_valid low: ignored (idle code).
- Word completion: the Nth valid symbol is accepted at edge K.
  - If the output register is free at edge K (dout_valid=0, or dout_valid && dout_ready), dout←assembled word and dout_valid=1 from K+1. Latency is one cycle.
  - Otherwise the word is dropped, overflow pulses at K+1, and dout is unchanged.
  - In either case sym_count←0.
- Output handshake:
  - dout_valid falls after a cycle with dout_ready high, unless a new word loads in that same cycle, in which case it stays high with the new dout.
  - dout_ready while dout_valid=0 has no effect.
- Timeout (TIMEOUT>0):
  - The idle counter resets on any sym_valid or frame_start and counts while sym_count>0.
  - When it reaches TIMEOUT, the partial word is dropped, timeout pulses, and the block goes to IDLE.
  - The counter is held at 0 while sym_count=0.
- Pulse outputs are registered and last exactly one cycle. Back-to-back events give back-to-back pulses.
- sym_valid is accepted every cycle; there is no minimum symbol spacing.

Test Plan:
- Defaults (2/8/MSB_FIRST=1), symbols 1,0,2,3 spaced 9 cycles, dout_ready=1 -> dout=8'h4B, dout_valid high exactly 1 cycle, one cycle after the 4th strobe; sym_count sequence 1,2,3,0.
- MSB_FIRST=0, same symbols -> dout=8'hE1; then symbols 3,3,3,3 -> dout=8'hFF. Also SYM_BITS=4, OUT_W=16, MSB_FIRST=1 with symbols A,B,C,D -> dout=16'hABCD.
- dout_ready=0; feed two full words (4B then E4) -> first word held at 8'h4B, overflow pulses once after the 8th symbol, dout stays 8'h4B. Raise dout_ready on the cycle the third word completes -> dout changes with no dout_valid gap.
- Symbols 1,0 then an erasure (sym_in=3'b100 with sym_valid) -> sym_err pulse, sym_count=0; next symbols 2,3,0,1 -> dout=8'hB1. Repeat with frame_start after 3 symbols, including frame_start coincident with sym_valid -> symbol ignored.
- Two symbols then silence, TIMEOUT=64 -> timeout pulses exactly 64 cycles after the last strobe, sym_count=0, no dout_valid.
- rst_n low for 1 cycle mid-word and again while dout_valid=1 -> all outputs 0 on the next cycle; the next 4 symbols assemble correctly.
